control_unit: RTL and testbench

//  Instruction decoder of the single-cycle MIPS-subset CPU. Splits a 32-bit instruction

---
 rtl/cu_pkg.sv | 27 ++
 rtl/cu_alu_decoder.sv | 39 +++
 rtl/control_unit.sv | 126 ++++++++++++
 tb/tb_control_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the instruction decoder: opcodes, R-type funct codes
// and the ALU operation select driven towards the datapath.
package cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_func_t;

endpackage

// File: rtl/cu_alu_decoder.sv
// Combinational (opcode, funct) -> ALU operation plus a valid flag.
// valid = 0 marks an unrecognised encoding; alu_func then defaults to ADD.
// Build option: CU_EXT_ALU_EN adds sub/and/or/slt R-type functs and andi.
module cu_alu_decoder
  import cu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_func_t  alu_func,
  output logic       valid
);

  // Map each supported encoding to its ALU operation.
  always_comb begin
    alu_func = ALU_ADD;
    valid    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: valid = 1'b1;
`ifdef CU_EXT_ALU_EN
          FN_SUB: begin alu_func = ALU_SUB; valid = 1'b1; end
          FN_AND: begin alu_func = ALU_AND; valid = 1'b1; end
          FN_OR:  begin alu_func = ALU_OR;  valid = 1'b1; end
          FN_SLT: begin alu_func = ALU_SLT; valid = 1'b1; end
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: valid = 1'b1;
      OP_ORI: begin alu_func = ALU_OR; valid = 1'b1; end
`ifdef CU_EXT_ALU_EN
      OP_ANDI: begin alu_func = ALU_AND; valid = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder for the single-cycle MIPS-subset core. Splits the
// instruction into register fields, extended immediate and control strobes;
// all outputs are registered (one clock latency).
// Build option: CU_EXT_ALU_EN (handled in cu_alu_decoder) widens the decoded
// set; encodings the ALU decoder rejects fall through to NOP here.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        jump,
  output logic [2:0]  alu_func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        ram_load,
  output logic        ram_write,
  output logic        signal_extension,
  output logic [31:0] ram_addr,
  output logic [15:0] jump_offset
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  alu_func_t   dec_alu;
  logic        dec_valid;

  logic        d_jump;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic        d_load;
  logic        d_write;
  logic        d_sext;
  logic [31:0] d_addr;
  logic [15:0] d_joff;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};
  assign imm_zext = {16'h0000, instruction[15:0]};

  cu_alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct    (funct),
    .alu_func (dec_alu),
    .valid    (dec_valid)
  );

  // Per-opcode control decode; anything the ALU decoder rejects stays NOP.
  always_comb begin
    d_jump  = 1'b0;
    d_rd    = 5'd0;
    d_imm   = 32'd0;
    d_load  = 1'b0;
    d_write = 1'b0;
    d_sext  = 1'b0;
    d_addr  = 32'd0;
    d_joff  = 16'd0;
    if (dec_valid) begin
      case (opcode)
        OP_RTYPE: d_rd = instruction[15:11];
        OP_ADDI: begin
          d_sext = 1'b1;
          d_imm  = imm_sext;
          d_rd   = instruction[20:16];
        end
        OP_ORI, OP_ANDI: begin
          d_imm = imm_zext;
          d_rd  = instruction[20:16];
        end
        OP_LW: begin
          d_load = 1'b1;
          d_sext = 1'b1;
          d_imm  = imm_sext;
          d_addr = imm_sext;
          d_rd   = instruction[20:16];
        end
        OP_SW: begin
          d_write = 1'b1;
          d_sext  = 1'b1;
          d_imm   = imm_sext;
          d_addr  = imm_sext;
        end
        OP_J: begin
          d_jump = 1'b1;
          d_joff = {instruction[13:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

  // Output register stage; async reset clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump             <= 1'b0;
      alu_func         <= 3'd0;
      rs               <= 5'd0;
      rt               <= 5'd0;
      rd               <= 5'd0;
      imm              <= 32'd0;
      ram_load         <= 1'b0;
      ram_write        <= 1'b0;
      signal_extension <= 1'b0;
      ram_addr         <= 32'd0;
      jump_offset      <= 16'd0;
    end else begin
      jump             <= d_jump;
      alu_func         <= dec_alu;
      rs               <= instruction[25:21];
      rt               <= instruction[20:16];
      rd               <= d_rd;
      imm              <= d_imm;
      ram_load         <= d_load;
      ram_write        <= d_write;
      signal_extension <= d_sext;
      ram_addr         <= d_addr;
      jump_offset      <= d_joff;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vectors, randomized
// instructions against a behavioural decode model, and reset behaviour.
module tb_control_unit;

`ifdef CU_EXT_ALU_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        jump;
  logic [2:0]  alu_func;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic        ram_load, ram_write, signal_extension;
  logic [31:0] ram_addr;
  logic [15:0] jump_offset;

  int n_checks = 0;
  int n_errors = 0;

  control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction      (instruction),
    .jump             (jump),
    .alu_func         (alu_func),
    .rs               (rs),
    .rt               (rt),
    .rd               (rd),
    .imm              (imm),
    .ram_load         (ram_load),
    .ram_write        (ram_write),
    .signal_extension (signal_extension),
    .ram_addr         (ram_addr),
    .jump_offset      (jump_offset)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        jump;
    logic [2:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ld;
    logic        st;
    logic        sext;
    logic [31:0] addr;
    logic [15:0] joff;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (instr %h)", tag, obs, exp, instruction);
    end
  endtask

  // Instruction-level meaning of each word, written from the ISA table.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int unsigned op  = w[31:26];
    int unsigned fn  = w[5:0];
    int unsigned i16 = w[15:0];
    logic [31:0] sx;
    logic [31:0] zx;
    e    = '0;
    e.rs = w[25:21];
    e.rt = w[20:16];
    zx   = i16;
    sx   = (i16 >= 32768) ? i16 - 32'd65536 : i16;
    case (op)
      0: begin
        if (fn == 32)            begin e.alu = 0; e.rd = w[15:11]; end
        else if (EXT && fn == 34) begin e.alu = 1; e.rd = w[15:11]; end
        else if (EXT && fn == 36) begin e.alu = 2; e.rd = w[15:11]; end
        else if (EXT && fn == 37) begin e.alu = 3; e.rd = w[15:11]; end
        else if (EXT && fn == 42) begin e.alu = 4; e.rd = w[15:11]; end
      end
      8:  begin e.sext = 1; e.imm = sx; e.rd = e.rt; end
      13: begin e.alu = 3; e.imm = zx; e.rd = e.rt; end
      12: if (EXT) begin e.alu = 2; e.imm = zx; e.rd = e.rt; end
      35: begin e.ld = 1; e.sext = 1; e.imm = sx; e.addr = sx; e.rd = e.rt; end
      43: begin e.st = 1; e.sext = 1; e.imm = sx; e.addr = sx; end
      2:  begin e.jump = 1; e.joff = 16'((w[25:0] * 4) % 65536); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".jump"}, 32'(jump), 32'(e.jump));
    check({tag, ".alu_func"}, 32'(alu_func), 32'(e.alu));
    check({tag, ".rs"}, 32'(rs), 32'(e.rs));
    check({tag, ".rt"}, 32'(rt), 32'(e.rt));
    check({tag, ".rd"}, 32'(rd), 32'(e.rd));
    check({tag, ".imm"}, imm, e.imm);
    check({tag, ".ram_load"}, 32'(ram_load), 32'(e.ld));
    check({tag, ".ram_write"}, 32'(ram_write), 32'(e.st));
    check({tag, ".sext"}, 32'(signal_extension), 32'(e.sext));
    check({tag, ".ram_addr"}, ram_addr, e.addr);
    check({tag, ".jump_offset"}, 32'(jump_offset), 32'(e.joff));
    check({tag, ".strobe_excl"}, 32'((ram_load & ram_write) | (jump & (ram_load | ram_write))), 32'd0);
  endtask

  task automatic apply(input string tag, input logic [31:0] w);
    instruction = w;
    @(posedge clk);
    #1;
    compare(tag, model(w));
  endtask

  logic [5:0] op_pool [8] = '{6'd0, 6'd8, 6'd13, 6'd12, 6'd35, 6'd43, 6'd2, 6'd63};
  logic [5:0] fn_pool [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};

  initial begin
    exp_t zero;
    logic [31:0] w;
    zero = '0;
    rst_n = 1'b0;
    instruction = {6'b101011, 5'd1, 5'd4, 16'd1};
    #1;
    compare("reset_pre_clk", zero);
    @(posedge clk);
    #1;
    compare("reset_held", zero);
    rst_n = 1'b1;

    apply("addi", {6'b001000, 5'd0, 5'd1, 16'd1});
    check("addi.imm_const", imm, 32'd1);
    apply("add", {6'b000000, 5'd0, 5'd1, 5'd2, 5'd0, 6'b100000});
    check("add.rd_const", 32'(rd), 32'd2);
    apply("addi_neg", {6'b001000, 5'd3, 5'd5, 16'hFFFF});
    check("addi_neg.imm_const", imm, 32'hFFFF_FFFF);
    apply("ori", {6'b001101, 5'd1, 5'd4, 16'd2});
    check("ori.alu_const", 32'(alu_func), 32'd3);
    apply("ori_8000", {6'b001101, 5'd1, 5'd4, 16'h8000});
    check("ori_8000.imm_const", imm, 32'h0000_8000);
    apply("sw", {6'b101011, 5'd1, 5'd4, 16'd1});
    check("sw.ram_addr_const", ram_addr, 32'd1);
    apply("lw", {6'b100011, 5'd1, 5'd4, 16'd1});
    check("lw.rd_const", 32'(rd), 32'd4);
    apply("j", {6'b000010, 26'd3});
    check("j.joff_const", 32'(jump_offset), 32'd12);
    apply("j_wrap", {6'b000010, 26'h3FF_FFFF});
    apply("nop_op63", {6'b111111, 26'h155_5555});
    apply("rtype_sub", {6'b000000, 5'd7, 5'd8, 5'd9, 5'd0, 6'b100010});
    check("rtype_sub.alu_const", 32'(alu_func), EXT ? 32'd1 : 32'd0);
    apply("andi", {6'b001100, 5'd2, 5'd6, 16'hF00F});

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[31:26] = op_pool[$urandom_range(7)];
      if (w[31:26] == 6'd0 && $urandom_range(3) != 0) w[5:0] = fn_pool[$urandom_range(5)];
      if (w[31:26] == 6'd63) w[31:26] = 6'($urandom);
      apply("rand", w);
    end

    // Reset mid-stream: outputs clear without a clock edge, decode resumes after release.
    apply("pre_reset", {6'b100011, 5'd9, 5'd10, 16'h8004});
    #2;
    rst_n = 1'b0;
    #1;
    compare("reset_async", zero);
    @(posedge clk);
    #1;
    compare("reset_mid_held", zero);
    rst_n = 1'b1;
    apply("post_reset", {6'b101011, 5'd11, 5'd12, 16'h7FF0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
